// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU control path: opcodes, ALU and
// accumulator-source codes, and the sequencer state encoding.
package cpu_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_STA = 4'h2;
   localparam logic [3:0] OP_ADD = 4'h3;
   localparam logic [3:0] OP_SUB = 4'h4;
   localparam logic [3:0] OP_AND = 4'h5;
   localparam logic [3:0] OP_OR  = 4'h6;
   localparam logic [3:0] OP_XOR = 4'h7;
   localparam logic [3:0] OP_JMP = 4'h8;
   localparam logic [3:0] OP_JZ  = 4'h9;
   localparam logic [3:0] OP_JC  = 4'hA;
   localparam logic [3:0] OP_IN  = 4'hB;
   localparam logic [3:0] OP_OUT = 4'hC;
   localparam logic [3:0] OP_LDI = 4'hD;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_XOR = 3'd4;

   localparam logic [1:0] SRC_ALU = 2'd0;
   localparam logic [1:0] SRC_MEM = 2'd1;
   localparam logic [1:0] SRC_IN  = 2'd2;
   localparam logic [1:0] SRC_IMM = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_MEM    = 3'd3,
      S_IN     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   // Memory-operand ALU opcodes (ADD..XOR) share one code space offset by OP_ADD.
   function automatic logic is_alu_op(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_XOR);
   endfunction

   function automatic logic [2:0] alu_code(input logic [3:0] op);
      logic [3:0] d;
      d = op - OP_ADD;
      return d[2:0];
   endfunction

endpackage

// File: rtl/cpu_mem_watchdog.sv
// Counts consecutive cycles a memory request waits without an ack and flags
// expiry on the TIMEOUT-th such cycle.
module cpu_mem_watchdog #(
   parameter int TIMEOUT = 15
) (
   input  logic clk_in,
   input  logic reset,
   input  logic wait_cyc,
   output logic expire
);

   logic [7:0] count;

   // Count only while a request is outstanding; any other cycle restarts it.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset)
         count <= 8'd0;
      else if (wait_cyc)
         count <= count + 8'd1;
      else
         count <= 8'd0;
   end

   // An ack arriving on the final cycle suppresses expiry because wait_cyc is low.
   assign expire = wait_cyc && (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_ctrl_sequencer.sv
// Multicycle fetch/decode/execute sequencer for the 8-bit accumulator CPU.
//
// state    | meaning
// S_IDLE   | one bubble after reset release, no strobes
// S_FETCH  | read instruction at PC; on ack load IR and bump PC
// S_DECODE | act on opcode: immediate/jump/out done here, else dispatch
// S_MEM    | operand access at ir[ADW-1:0]; read or write by opcode
// S_IN     | wait for input register to hold fresh data
// S_HALT   | stopped by HLT or memory timeout; left only by reset
module cpu_ctrl_sequencer
   import cpu_pkg::*;
#(
   parameter int ADW     = 4,
   parameter int TIMEOUT = 15
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic [7:0] ir,
   input  logic       zero_flag,
   input  logic       carry_flag,
   input  logic       mem_ack,
   input  logic       in_valid,
   output logic       mem_req,
   output logic       mem_we,
   output logic       addr_sel,
   output logic       ir_load,
   output logic       pc_inc,
   output logic       pc_load,
   output logic       acc_load,
   output logic [1:0] acc_src,
   output logic [2:0] alu_op,
   output logic       out_load,
   output logic       in_ack,
   output logic       halted,
   output logic       fault
);

   state_t     state, state_next;
   logic [3:0] op;
   logic       expire;
   logic       unused_operand;

   assign op = ir[7:4];
   // The operand field feeds the datapath address mux, not the sequencer.
   assign unused_operand = ^ir[ADW-1:0];

   cpu_mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk_in   (clk_in),
      .reset    (reset),
      .wait_cyc (mem_req && !mem_ack),
      .expire   (expire)
   );

   // State register.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   // Halted mirrors the upcoming state; fault latches a timeout until reset.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         halted <= 1'b0;
         fault  <= 1'b0;
      end else begin
         halted <= (state_next == S_HALT);
         fault  <= fault | expire;
      end
   end

   // Next-state selection.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   state_next = S_FETCH;
         S_FETCH: begin
            if (mem_ack)     state_next = S_DECODE;
            else if (expire) state_next = S_HALT;
         end
         S_DECODE: begin
            case (op)
               OP_LDA, OP_STA, OP_ADD, OP_SUB,
               OP_AND, OP_OR, OP_XOR:          state_next = S_MEM;
               OP_IN:                          state_next = S_IN;
               OP_HLT:                         state_next = S_HALT;
               default:                        state_next = S_FETCH;
            endcase
         end
         S_MEM: begin
            if (mem_ack)     state_next = S_FETCH;
            else if (expire) state_next = S_HALT;
         end
         S_IN:     if (in_valid) state_next = S_FETCH;
         S_HALT:   state_next = S_HALT;
         default:  state_next = S_IDLE;
      endcase
   end

   // Strobe decode from state, opcode, flags and handshake inputs.
   always_comb begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      addr_sel = 1'b0;
      ir_load  = 1'b0;
      pc_inc   = 1'b0;
      pc_load  = 1'b0;
      acc_load = 1'b0;
      acc_src  = SRC_ALU;
      alu_op   = ALU_ADD;
      out_load = 1'b0;
      in_ack   = 1'b0;
      case (state)
         S_FETCH: begin
            mem_req = 1'b1;
            ir_load = mem_ack;
            pc_inc  = mem_ack;
         end
         S_DECODE: begin
            case (op)
               OP_LDI: begin
                  acc_load = 1'b1;
                  acc_src  = SRC_IMM;
               end
               OP_JMP:  pc_load  = 1'b1;
               OP_JZ:   pc_load  = zero_flag;
               OP_JC:   pc_load  = carry_flag;
               OP_OUT:  out_load = 1'b1;
               default: ;
            endcase
         end
         S_MEM: begin
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            mem_we   = (op == OP_STA);
            if (mem_ack) begin
               if (op == OP_LDA) begin
                  acc_load = 1'b1;
                  acc_src  = SRC_MEM;
               end else if (is_alu_op(op)) begin
                  acc_load = 1'b1;
                  acc_src  = SRC_ALU;
                  alu_op   = alu_code(op);
               end
            end
         end
         S_IN: begin
            if (in_valid) begin
               acc_load = 1'b1;
               acc_src  = SRC_IN;
               in_ack   = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cpu_ctrl_sequencer.sv
// Directed bench for the CPU control sequencer: per-instruction vector table
// plus hand sequences for wait states, input stall, halt and timeout.
module tb_cpu_ctrl_sequencer;

   logic       clk_in = 1'b0;
   logic       reset;
   logic [7:0] ir;
   logic       zero_flag, carry_flag, mem_ack, in_valid;
   logic       mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load;
   logic       acc_load, out_load, in_ack, halted, fault;
   logic [1:0] acc_src;
   logic [2:0] alu_op;

   int n_chk  = 0;
   int n_pass = 0;

   cpu_ctrl_sequencer #(.ADW(4), .TIMEOUT(15)) dut (
      .clk_in     (clk_in),
      .reset      (reset),
      .ir         (ir),
      .zero_flag  (zero_flag),
      .carry_flag (carry_flag),
      .mem_ack    (mem_ack),
      .in_valid   (in_valid),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .addr_sel   (addr_sel),
      .ir_load    (ir_load),
      .pc_inc     (pc_inc),
      .pc_load    (pc_load),
      .acc_load   (acc_load),
      .acc_src    (acc_src),
      .alu_op     (alu_op),
      .out_load   (out_load),
      .in_ack     (in_ack),
      .halted     (halted),
      .fault      (fault)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [7:0] ir;
      logic       zf;
      logic       cf;
      logic       dec_acc;
      logic [1:0] dec_src;
      logic       dec_pcl;
      logic       dec_out;
      logic       is_mem;
      logic       we;
      logic       mem_acc;
      logic [1:0] mem_src;
      logic       is_alu;
      logic [2:0] alu;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic next_cyc();
      @(negedge clk_in);
   endtask

   // Enters with reset asserted at the current time; leaves at the start of FETCH.
   task automatic do_reset();
      reset    = 1'b1;
      mem_ack  = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("rst_mem_req", {7'd0, mem_req}, 8'd0);
      chk("rst_halted",  {7'd0, halted},  8'd0);
      chk("rst_fault",   {7'd0, fault},   8'd0);
      chk("rst_strobes", {ir_load, pc_inc, pc_load, acc_load, out_load, in_ack, mem_we, addr_sel}, 8'd0);
      next_cyc();
      reset = 1'b0;
      #1;
      chk("idle_bubble", {7'd0, mem_req}, 8'd0);
      next_cyc();
   endtask

   // Completes a fetch with an immediate ack; leaves at the start of DECODE.
   task automatic do_fetch(input logic [7:0] v);
      ir      = v;
      mem_ack = 1'b1;
      #1;
      chk("fetch_req",   {7'd0, mem_req},  8'd1);
      chk("fetch_addr",  {7'd0, addr_sel}, 8'd0);
      chk("fetch_we",    {7'd0, mem_we},   8'd0);
      chk("fetch_irld",  {7'd0, ir_load},  8'd1);
      chk("fetch_pcinc", {7'd0, pc_inc},   8'd1);
      next_cyc();
      mem_ack = 1'b0;
   endtask

   initial begin
      ir = 8'h00; zero_flag = 1'b0; carry_flag = 1'b0;
      //           ir     zf cf dAcc dSrc  dPcl dOut mem we mAcc mSrc alu? code
      vecs[0]  = '{8'h00, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 3'd0};
      vecs[1]  = '{8'hD7, 0, 0, 1, 2'd3, 0, 0, 0, 0, 0, 2'd0, 0, 3'd0};
      vecs[2]  = '{8'hC0, 0, 0, 0, 2'd0, 0, 1, 0, 0, 0, 2'd0, 0, 3'd0};
      vecs[3]  = '{8'h8A, 0, 0, 0, 2'd0, 1, 0, 0, 0, 0, 2'd0, 0, 3'd0};
      vecs[4]  = '{8'h9A, 1, 0, 0, 2'd0, 1, 0, 0, 0, 0, 2'd0, 0, 3'd0};
      vecs[5]  = '{8'h9A, 0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 3'd0};
      vecs[6]  = '{8'hA3, 0, 1, 0, 2'd0, 1, 0, 0, 0, 0, 2'd0, 0, 3'd0};
      vecs[7]  = '{8'hA3, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 3'd0};
      vecs[8]  = '{8'hE0, 1, 1, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 3'd0};
      vecs[9]  = '{8'h15, 0, 0, 0, 2'd0, 0, 0, 1, 0, 1, 2'd1, 0, 3'd0};
      vecs[10] = '{8'h25, 0, 0, 0, 2'd0, 0, 0, 1, 1, 0, 2'd0, 0, 3'd0};
      vecs[11] = '{8'h35, 0, 0, 0, 2'd0, 0, 0, 1, 0, 1, 2'd0, 1, 3'd0};
      vecs[12] = '{8'h45, 0, 0, 0, 2'd0, 0, 0, 1, 0, 1, 2'd0, 1, 3'd1};
      vecs[13] = '{8'h55, 0, 0, 0, 2'd0, 0, 0, 1, 0, 1, 2'd0, 1, 3'd2};
      vecs[14] = '{8'h65, 0, 0, 0, 2'd0, 0, 0, 1, 0, 1, 2'd0, 1, 3'd3};
      vecs[15] = '{8'h75, 0, 0, 0, 2'd0, 0, 0, 1, 0, 1, 2'd0, 1, 3'd4};

      do_reset();

      // Table: one instruction per entry, immediate ack on every request.
      for (int i = 0; i < 16; i++) begin
         do_fetch(vecs[i].ir);
         zero_flag  = vecs[i].zf;
         carry_flag = vecs[i].cf;
         #1;
         chk("dec_req",   {7'd0, mem_req},  8'd0);
         chk("dec_acc",   {7'd0, acc_load}, {7'd0, vecs[i].dec_acc});
         if (vecs[i].dec_acc) chk("dec_src", {6'd0, acc_src}, {6'd0, vecs[i].dec_src});
         chk("dec_pcl",   {7'd0, pc_load},  {7'd0, vecs[i].dec_pcl});
         chk("dec_out",   {7'd0, out_load}, {7'd0, vecs[i].dec_out});
         next_cyc();
         if (vecs[i].is_mem) begin
            #1;
            chk("mem_req",  {7'd0, mem_req},  8'd1);
            chk("mem_addr", {7'd0, addr_sel}, 8'd1);
            chk("mem_we",   {7'd0, mem_we},   {7'd0, vecs[i].we});
            mem_ack = 1'b1;
            #1;
            chk("mem_acc",  {7'd0, acc_load}, {7'd0, vecs[i].mem_acc});
            if (vecs[i].mem_acc) chk("mem_src", {6'd0, acc_src}, {6'd0, vecs[i].mem_src});
            if (vecs[i].is_alu)  chk("mem_alu", {5'd0, alu_op},  {5'd0, vecs[i].alu});
            next_cyc();
            mem_ack = 1'b0;
         end
         #1;
         chk("back_fetch", {6'd0, mem_req, addr_sel}, 8'b10);
      end

      // ADD with ack withheld for 3 cycles in S_MEM.
      do_fetch(8'h35);
      next_cyc();
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("wait_req",  {6'd0, mem_req, addr_sel}, 8'b11);
         chk("wait_acc",  {7'd0, acc_load}, 8'd0);
         next_cyc();
      end
      mem_ack = 1'b1;
      #1;
      chk("late_ack", {acc_load, acc_src, alu_op, mem_req, addr_sel}, {1'b1, 2'd0, 3'd0, 2'b11});
      next_cyc();
      mem_ack = 1'b0;

      // IN with input not ready for 10 cycles.
      do_fetch(8'hB0);
      #1;
      chk("in_dec", {acc_load, in_ack, mem_req, 5'd0}, 8'd0);
      next_cyc();
      for (int k = 0; k < 10; k++) begin
         #1;
         chk("in_stall", {acc_load, in_ack, mem_req, 5'd0}, 8'd0);
         next_cyc();
      end
      in_valid = 1'b1;
      #1;
      chk("in_take", {acc_load, in_ack, acc_src, 4'd0}, {1'b1, 1'b1, 2'd2, 4'd0});
      next_cyc();
      in_valid = 1'b0;
      #1;
      chk("in_back_fetch", {6'd0, mem_req, addr_sel}, 8'b10);

      // Ack on the 15th waiting cycle still completes normally.
      for (int k = 0; k < 14; k++) begin
         #1;
         chk("slow_fetch_req", {7'd0, mem_req}, 8'd1);
         next_cyc();
      end
      do_fetch(8'h00);
      #1;
      chk("edge_ack_ok", {halted, fault, mem_req, 5'd0}, 8'd0);
      next_cyc();

      // Reset while a fetch is pending drops the request immediately.
      #1;
      chk("pre_rst_req", {7'd0, mem_req}, 8'd1);
      do_reset();

      // HLT halts without fault and ignores stray acks.
      do_fetch(8'hF0);
      next_cyc();
      #1;
      chk("hlt_state", {halted, fault, mem_req, 5'd0}, 8'b1000_0000);
      mem_ack = 1'b1;
      next_cyc();
      #1;
      chk("hlt_stay", {halted, fault, mem_req, ir_load, 4'd0}, 8'b1000_0000);
      mem_ack = 1'b0;
      do_reset();

      // Timeout: no ack for 15 request cycles.
      for (int k = 0; k < 15; k++) begin
         #1;
         chk("to_wait", {halted, fault, mem_req, 5'd0}, 8'b0010_0000);
         next_cyc();
      end
      #1;
      chk("to_fault", {halted, fault, mem_req, 5'd0}, 8'b1100_0000);
      next_cyc();
      #1;
      chk("to_sticky", {halted, fault, mem_req, 5'd0}, 8'b1100_0000);
      do_reset();
      #1;
      chk("post_to_fetch", {6'd0, mem_req, addr_sel}, 8'b10);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
